// File: rtl/pulse_count_ctrl.sv
// pulse_count_ctrl: synchronised edge-counting BCD sequencer with start/stop control, target done pulse and wrap carry
module pulse_count_ctrl #(
  parameter int DIGITS      = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                x,
  input  logic                start,
  input  logic                stop,
  input  logic [4*DIGITS-1:0] target,
  output logic [4*DIGITS-1:0] count,
  output logic                z,
  output logic                done,
  output logic                busy,
  output logic [1:0]          state
);
  typedef enum logic [1:0] {IDLE = 2'b00, COUNT = 2'b01, HOLD = 2'b10, DONE = 2'b11} state_t;
  state_t                st, st_nx;
  logic [SYNC_STAGES-1:0] sync;
  logic                  prev, evt, carry, z_nx;
  logic [4*DIGITS-1:0]   inc, count_nx;
  assign evt = sync[SYNC_STAGES-1] & ~prev;
  always_comb begin
    carry = 1'b1;
    inc   = count;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (count[4*i+:4] == 4'd9) inc[4*i+:4] = 4'd0;
        else begin
          inc[4*i+:4] = count[4*i+:4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end
  always_comb begin
    st_nx    = st;
    count_nx = count;
    z_nx     = 1'b0;
    case (st)
      IDLE: if (start && !stop) begin
        st_nx    = COUNT;
        count_nx = '0;
      end
      COUNT: if (evt) begin
        count_nx = inc;
        z_nx     = carry;
        st_nx    = (|target && inc == target) ? DONE : stop ? HOLD : COUNT;
      end else if (stop) st_nx = HOLD;
      HOLD:    st_nx = stop ? IDLE : start ? COUNT : HOLD;
      DONE:    st_nx = IDLE;
      default: st_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st    <= IDLE;
      count <= '0;
      z     <= 1'b0;
      sync  <= '0;
      prev  <= 1'b0;
    end else begin
      st    <= st_nx;
      count <= count_nx;
      z     <= z_nx;
      sync  <= {sync[SYNC_STAGES-2:0], x};
      prev  <= sync[SYNC_STAGES-1];
    end
  end
  assign done  = st == DONE;
  assign busy  = st == COUNT || st == HOLD;
  assign state = st;
endmodule

// File: tb/tb_pulse_count_ctrl.sv
// tb_pulse_count_ctrl: random and directed stimulus against a decimal-arithmetic reference model
module tb_pulse_count_ctrl;
  localparam int D = 2;
  localparam int S = 2;
  localparam int MAX = 100;
  logic clk = 0, rst = 1, x = 0, start = 0, stop = 0;
  logic [4*D-1:0] target = '0, count;
  logic z, done, busy;
  logic [1:0] state;
  int n_cmp = 0, n_bad = 0;
  int m_mode = 0, m_cnt = 0, m_z = 0;
  logic hist [0:S];
  int x_left = 2;
  pulse_count_ctrl #(.DIGITS(D), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst(rst), .x(x), .start(start), .stop(stop), .target(target),
    .count(count), .z(z), .done(done), .busy(busy), .state(state)
  );
  always #5 clk = ~clk;
  function automatic logic [4*D-1:0] to_bcd(int v);
    logic [4*D-1:0] b;
    for (int i = 0; i < D; i++) begin
      b[4*i+:4] = 4'(v % 10);
      v = v / 10;
    end
    return b;
  endfunction
  function automatic int from_bcd(logic [4*D-1:0] b);
    int v = 0;
    for (int i = D - 1; i >= 0; i--) begin
      if (b[4*i+:4] > 4'd9) return -1;
      v = v * 10 + int'(b[4*i+:4]);
    end
    return v;
  endfunction
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_edge();
    int t;
    bit evt;
    if (rst) begin
      m_mode = 0;
      m_cnt  = 0;
      m_z    = 0;
      for (int k = 0; k <= S; k++) hist[k] = 0;
      return;
    end
    evt = hist[S-1] && !hist[S];
    t = from_bcd(target);
    m_z = 0;
    case (m_mode)
      0: if (start && !stop) begin m_mode = 1; m_cnt = 0; end
      1: if (evt) begin
        if (m_cnt + 1 == MAX) m_z = 1;
        m_cnt = (m_cnt + 1) % MAX;
        if (t > 0 && m_cnt == t) m_mode = 3;
        else if (stop) m_mode = 2;
      end else if (stop) m_mode = 2;
      2: if (stop) m_mode = 0; else if (start) m_mode = 1;
      default: m_mode = 0;
    endcase
    for (int k = S; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = x;
  endtask
  task automatic cyc(bit r, bit sa, bit so);
    rst   = r;
    start = sa;
    stop  = so;
    if (--x_left == 0) begin
      x = ~x;
      x_left = $urandom_range(2, 4);
    end
    @(posedge clk);
    model_edge();
    #1;
    chk("count", 32'(count), 32'(to_bcd(m_cnt)));
    chk("state", 32'(state), 32'(m_mode));
    chk("z", 32'(z), 32'(m_z));
    chk("done", 32'(done), 32'(m_mode == 3));
    chk("busy", 32'(busy), 32'(m_mode == 1 || m_mode == 2));
  endtask
  initial begin
    logic [4*D-1:0] tgts [0:5];
    tgts[0] = 8'h05; tgts[1] = 8'h00; tgts[2] = 8'h10;
    tgts[3] = 8'h1A; tgts[4] = 8'h99; tgts[5] = 8'h03;
    for (int k = 0; k <= S; k++) hist[k] = 0;
    repeat (3) cyc(1, 0, 0);
    target = 8'h05;
    cyc(0, 1, 0);
    repeat (60) cyc(0, 0, 0);
    target = 8'h00;
    cyc(0, 1, 0);
    repeat (750) cyc(0, 0, 0);
    target = 8'h10;
    cyc(0, 1, 0);
    repeat (20) cyc(0, 0, 0);
    cyc(0, 0, 1);
    repeat (15) cyc(0, 0, 0);
    cyc(0, 1, 0);
    repeat (60) cyc(0, 0, 0);
    target = 8'h1A;
    cyc(0, 1, 0);
    repeat (40) cyc(0, 0, 0);
    cyc(1, 0, 0);
    cyc(0, 1, 0);
    repeat (750) cyc(0, 0, 0);
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 99) == 0) target = tgts[$urandom_range(0, 5)];
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
